nuc_sampler: RTL and testbench



---
 rtl/nuc_sampler.sv | 198 +++++++++++++++++++
 tb/tb_nuc_sampler.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nuc_sampler.sv
// Multi-lane nucleotide sampler: each lane draws from a Galois LFSR and rejection-samples
// a weighted A/C/G/T symbol; the samples of all lanes are offered together as one transfer.
module nuc_sampler #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned PW    = 10,
    parameter int unsigned TOTAL = 1000,
    parameter int unsigned LW    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [PW-1:0]       prob_a,
    input  logic [PW-1:0]       prob_c,
    input  logic [PW-1:0]       prob_g,
    input  logic [PW-1:0]       prob_t,
    input  logic [LW-1:0]       seed,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*N_CH-1:0]   out_sym,
    output logic                cfg_err,
    output logic [31:0]         out_count
);

    localparam int unsigned CW = PW + 2;
    localparam int unsigned SW = 2 * N_CH;
    localparam logic [LW-1:0] TAPS = LW'(32'h0000_B400);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wa_q, wa_d, wc_q, wc_d, wg_q, wg_d, wt_q, wt_d;
    logic [LW-1:0]   seed_q, seed_d;
    logic [CW-1:0]   ca_q, ca_d, cc_q, cc_d, cg_q, cg_d, ct_q, ct_d;
    logic [LW-1:0]   lfsr_q [N_CH];
    logic [LW-1:0]   lfsr_d [N_CH];
    logic [N_CH-1:0] full_q, full_d;
    logic [SW-1:0]   sym_q, sym_d;
    logic            out_valid_q, out_valid_d;
    logic            cfg_err_q, cfg_err_d;
    logic [31:0]     out_count_q, out_count_d;

    logic [CW-1:0]   sum_a, sum_c, sum_g, sum_t;
    logic [LW-1:0]   lfsr_adv  [N_CH];
    logic [LW-1:0]   lfsr_seed [N_CH];
    logic [N_CH-1:0] draw_hit;
    logic [1:0]      draw_sym  [N_CH];
    logic            cfg_accept;

    function automatic logic [LW-1:0] lfsr_step(input logic [LW-1:0] v);
        return v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
    endfunction

    assign cfg_ready  = (state_q == S_IDLE) || (state_q == S_ERR) ||
                        ((state_q == S_RUN) && !out_valid_q);
    assign cfg_accept = cfg_valid && cfg_ready;
    assign out_valid  = out_valid_q;
    assign out_sym    = sym_q;
    assign cfg_err    = cfg_err_q;
    assign out_count  = out_count_q;

    // Cumulative bounds from the latched weights, wide enough that no sum can overflow
    assign sum_a = CW'(wa_q);
    assign sum_c = sum_a + CW'(wc_q);
    assign sum_g = sum_c + CW'(wg_q);
    assign sum_t = sum_g + CW'(wt_q);

    // Per-lane draw: r is the low PW bits of the current LFSR state; r >= cT is rejected
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            lfsr_adv[i]  = lfsr_step(lfsr_q[i]);
            lfsr_seed[i] = ((seed_q ^ LW'(i + 1)) == '0) ? LW'(1) : (seed_q ^ LW'(i + 1));
            draw_hit[i]  = CW'(lfsr_q[i][PW-1:0]) < ct_q;
            if (CW'(lfsr_q[i][PW-1:0]) < ca_q) begin
                draw_sym[i] = 2'b00;
            end else if (CW'(lfsr_q[i][PW-1:0]) < cc_q) begin
                draw_sym[i] = 2'b01;
            end else if (CW'(lfsr_q[i][PW-1:0]) < cg_q) begin
                draw_sym[i] = 2'b10;
            end else begin
                draw_sym[i] = 2'b11;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        wa_d        = wa_q;
        wc_d        = wc_q;
        wg_d        = wg_q;
        wt_d        = wt_q;
        seed_d      = seed_q;
        ca_d        = ca_q;
        cc_d        = cc_q;
        cg_d        = cg_q;
        ct_d        = ct_q;
        lfsr_d      = lfsr_q;
        full_d      = full_q;
        sym_d       = sym_q;
        cfg_err_d   = cfg_err_q;
        out_count_d = out_count_q;

        case (state_q)
            S_LOAD: begin
                ca_d   = sum_a;
                cc_d   = sum_c;
                cg_d   = sum_g;
                ct_d   = sum_t;
                lfsr_d = lfsr_seed;
                if ((sum_t > CW'(TOTAL)) || (sum_t == '0)) begin
                    cfg_err_d = 1'b1;
                    state_d   = S_ERR;
                end else begin
                    cfg_err_d = 1'b0;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                for (int i = 0; i < N_CH; i++) begin
                    if (!full_q[i]) begin
                        lfsr_d[i] = lfsr_adv[i];
                        if (draw_hit[i]) begin
                            full_d[i]        = 1'b1;
                            sym_d[2*i +: 2]  = draw_sym[i];
                        end
                    end
                end
                // Full lanes never draw, so a transfer cannot collide with a new sample
                if (out_valid_q && out_ready) begin
                    full_d      = '0;
                    out_count_d = out_count_q + 32'd1;
                end
            end
            default: ;
        endcase

        if (cfg_accept) begin
            wa_d        = prob_a;
            wc_d        = prob_c;
            wg_d        = prob_g;
            wt_d        = prob_t;
            seed_d      = seed;
            out_count_d = '0;
            full_d      = '0;
            state_d     = S_LOAD;
        end

        out_valid_d = (state_d == S_RUN) && (&full_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wa_q        <= '0;
            wc_q        <= '0;
            wg_q        <= '0;
            wt_q        <= '0;
            seed_q      <= '0;
            ca_q        <= '0;
            cc_q        <= '0;
            cg_q        <= '0;
            ct_q        <= '0;
            for (int i = 0; i < N_CH; i++) begin
                lfsr_q[i] <= LW'(1);
            end
            full_q      <= '0;
            sym_q       <= '0;
            out_valid_q <= 1'b0;
            cfg_err_q   <= 1'b0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            wa_q        <= wa_d;
            wc_q        <= wc_d;
            wg_q        <= wg_d;
            wt_q        <= wt_d;
            seed_q      <= seed_d;
            ca_q        <= ca_d;
            cc_q        <= cc_d;
            cg_q        <= cg_d;
            ct_q        <= ct_d;
            for (int i = 0; i < N_CH; i++) begin
                lfsr_q[i] <= lfsr_d[i];
            end
            full_q      <= full_d;
            sym_q       <= sym_d;
            out_valid_q <= out_valid_d;
            cfg_err_q   <= cfg_err_d;
            out_count_q <= out_count_d;
        end
    end

endmodule

// File: tb/tb_nuc_sampler.sv
// Directed bench for nuc_sampler: a lane-level LFSR/rejection model predicts each transfer's
// symbols into a queue that is popped and compared as transfers complete.
module tb_nuc_sampler;

    localparam int unsigned N_CH  = 4;
    localparam int unsigned PW    = 10;
    localparam int unsigned TOTAL = 1000;
    localparam int unsigned LW    = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [PW-1:0]     prob_a, prob_c, prob_g, prob_t;
    logic [LW-1:0]     seed;
    logic              out_valid;
    logic              out_ready;
    logic [2*N_CH-1:0] out_sym;
    logic              cfg_err;
    logic [31:0]       out_count;

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_q [$];
    logic [15:0] m_lfsr [N_CH];
    int          m_ca, m_cc, m_cg, m_ct;
    int          hist [4];

    always #5 clk = ~clk;

    nuc_sampler #(.N_CH(N_CH), .PW(PW), .TOTAL(TOTAL), .LW(LW)) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .prob_a    (prob_a),
        .prob_c    (prob_c),
        .prob_g    (prob_g),
        .prob_t    (prob_t),
        .seed      (seed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sym   (out_sym),
        .cfg_err   (cfg_err),
        .out_count (out_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: each lane keeps drawing until one value falls below cT
    task automatic predict(output logic [7:0] s);
        int  r;
        bit  got;
        s = '0;
        for (int i = 0; i < N_CH; i++) begin
            got = 1'b0;
            for (int k = 0; k < 100000 && !got; k++) begin
                r = int'(m_lfsr[i] & 16'h03FF);
                m_lfsr[i] = m_lfsr[i][0] ? ((m_lfsr[i] >> 1) ^ 16'hB400) : (m_lfsr[i] >> 1);
                if (r < m_ct) begin
                    got = 1'b1;
                    s[2*i +: 2] = (r < m_ca) ? 2'd0 : (r < m_cc) ? 2'd1 : (r < m_cg) ? 2'd2 : 2'd3;
                end
            end
        end
    endtask

    task automatic do_cfg(input int a, input int c, input int g, input int t, input logic [15:0] sd);
        int n;
        n = 0;
        prob_a = PW'(a);
        prob_c = PW'(c);
        prob_g = PW'(g);
        prob_t = PW'(t);
        seed = sd;
        cfg_valid = 1'b1;
        while (!cfg_ready && n < 100) begin
            step();
            n++;
        end
        chk("cfg_ready_wait", 32'(cfg_ready), 32'd1);
        step();
        cfg_valid = 1'b0;
        // Weights wiggling without a handshake must be ignored
        prob_a = PW'($urandom);
        prob_c = PW'($urandom);
        prob_g = PW'($urandom);
        prob_t = PW'($urandom);
        seed = LW'($urandom);
        m_ca = a;
        m_cc = a + c;
        m_cg = a + c + g;
        m_ct = a + c + g + t;
        for (int i = 0; i < N_CH; i++) begin
            m_lfsr[i] = sd ^ 16'(i + 1);
            if (m_lfsr[i] == 16'h0) m_lfsr[i] = 16'h1;
        end
    endtask

    task automatic xfer(input int n);
        int done;
        int cyc;
        logic [7:0] e;
        done = 0;
        cyc = 0;
        for (int k = 0; k < n; k++) begin
            predict(e);
            exp_q.push_back(e);
        end
        out_ready = 1'b1;
        while (done < n && cyc < n * 300) begin
            if (out_valid) begin
                e = exp_q.pop_front();
                chk("out_sym", 32'(out_sym), 32'(e));
                for (int i = 0; i < N_CH; i++) hist[out_sym[2*i +: 2]]++;
                done++;
            end
            step();
            cyc++;
        end
        out_ready = 1'b0;
        chk("xfer_done", 32'(done), 32'(n));
    endtask

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        while (!out_valid && n < budget) begin
            step();
            n++;
        end
        chk("wait_valid", 32'(out_valid), 32'd1);
    endtask

    initial begin
        logic [7:0]  s0;
        logic [7:0]  e;
        logic [31:0] c0;
        bit          ok;

        reset = 1'b1;
        cfg_valid = 1'b0;
        out_ready = 1'b0;
        prob_a = '0;
        prob_c = '0;
        prob_g = '0;
        prob_t = '0;
        seed = '0;
        for (int k = 0; k < 4; k++) hist[k] = 0;
        repeat (3) step();
        reset = 1'b0;
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sym", 32'(out_sym), 32'd0);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
        chk("rst_out_count", out_count, 32'd0);

        // All weight on A
        do_cfg(1000, 0, 0, 0, 16'h1234);
        chk("load_cfg_ready", 32'(cfg_ready), 32'd0);
        chk("load_out_valid", 32'(out_valid), 32'd0);
        xfer(50);
        chk("count_50", out_count, 32'd50);

        // Sum over TOTAL -> error, no output
        do_cfg(500, 501, 0, 0, 16'hBEEF);
        step();
        chk("err_set", 32'(cfg_err), 32'd1);
        ok = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (out_valid) ok = 1'b0;
            step();
        end
        chk("err_no_valid", 32'(ok), 32'd1);
        chk("err_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("err_count_clr", out_count, 32'd0);

        do_cfg(0, 0, 0, 1000, 16'h0F0F);
        step();
        chk("err_clear", 32'(cfg_err), 32'd0);
        xfer(20);

        // Zero total is also an error
        do_cfg(0, 0, 0, 0, 16'h0001);
        step();
        chk("zero_err", 32'(cfg_err), 32'd1);

        // Backpressure: output frozen while not taken
        do_cfg(0, 0, 0, 1000, 16'h0003);
        predict(e);
        exp_q.push_back(e);
        wait_valid(300);
        s0 = out_sym;
        c0 = out_count;
        ok = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            if (out_sym !== s0 || out_valid !== 1'b1 || out_count !== c0) ok = 1'b0;
        end
        chk("hold_stable", 32'(ok), 32'd1);
        e = exp_q.pop_front();
        chk("hold_sym", 32'(s0), 32'(e));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("hold_count_inc", out_count, c0 + 32'd1);
        chk("hold_valid_drop", 32'(out_valid), 32'd0);

        // Uniform distribution
        for (int k = 0; k < 4; k++) hist[k] = 0;
        do_cfg(250, 250, 250, 250, 16'hACE1);
        xfer(1000);
        chk("hist_A", 32'(hist[0] >= 900 && hist[0] <= 1100), 32'd1);
        chk("hist_C", 32'(hist[1] >= 900 && hist[1] <= 1100), 32'd1);
        chk("hist_G", 32'(hist[2] >= 900 && hist[2] <= 1100), 32'd1);
        chk("hist_T", 32'(hist[3] >= 900 && hist[3] <= 1100), 32'd1);
        chk("count_1000", out_count, 32'd1000);

        // Only A/C allowed
        for (int k = 0; k < 4; k++) hist[k] = 0;
        do_cfg(100, 100, 0, 0, 16'h5A5A);
        xfer(30);
        chk("ac_no_G", 32'(hist[2]), 32'd0);
        chk("ac_no_T", 32'(hist[3]), 32'd0);

        // Reset while a sample is pending and being taken
        do_cfg(250, 250, 250, 250, 16'h7777);
        xfer(3);
        wait_valid(300);
        out_ready = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_count", out_count, 32'd0);
        chk("mid_rst_sym", 32'(out_sym), 32'd0);
        chk("mid_rst_ready", 32'(cfg_ready), 32'd1);
        step();
        chk("mid_rst_idle", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
